// File: rtl/regbank_alu_sequencer_pkg.sv
// Shared types for the register-bank ALU sequencer: opcodes, FSM states
// and default geometry.
package regbank_seq_pkg;

  localparam int unsigned OP_W      = 3;
  localparam int unsigned DEF_WIDTH = 16;
  localparam int unsigned DEF_DEPTH = 8;

  typedef enum logic [OP_W-1:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_AND  = 3'd2,
    OP_OR   = 3'd3,
    OP_XOR  = 3'd4,
    OP_PASS = 3'd5,
    OP_INC  = 3'd6,
    OP_NOP  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_EXEC  = 2'd2,
    S_WRITE = 2'd3
  } state_e;

endpackage

// File: rtl/regbank_alu_sequencer_if.sv
// Command handshake plus register-bank read/write bus of the sequencer.
//   cmd_*      : command in (valid/ready), opcode, rd/rs1/rs2
//   rf_raddr_* : read addresses to bank, rf_rdata_* combinational data back
//   rf_we/rf_waddr/rf_wdata : bank write port
//   done, flag_zero, flag_carry : completion pulse and ALU flags
// slave = sequencer side, master = controller/bank side.
interface regbank_alu_sequencer_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned AW    = 3
);
  logic                            cmd_valid;
  logic                            cmd_ready;
  logic [regbank_seq_pkg::OP_W-1:0] cmd_op;
  logic [AW-1:0]                   cmd_rd;
  logic [AW-1:0]                   cmd_rs1;
  logic [AW-1:0]                   cmd_rs2;
  logic [AW-1:0]                   rf_raddr_a;
  logic [AW-1:0]                   rf_raddr_b;
  logic [WIDTH-1:0]                rf_rdata_a;
  logic [WIDTH-1:0]                rf_rdata_b;
  logic                            rf_we;
  logic [AW-1:0]                   rf_waddr;
  logic [WIDTH-1:0]                rf_wdata;
  logic                            done;
  logic                            flag_zero;
  logic                            flag_carry;

  modport slave (
    input  cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, rf_rdata_a, rf_rdata_b,
    output cmd_ready, rf_raddr_a, rf_raddr_b, rf_we, rf_waddr, rf_wdata,
           done, flag_zero, flag_carry
  );

  modport master (
    output cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, rf_rdata_a, rf_rdata_b,
    input  cmd_ready, rf_raddr_a, rf_raddr_b, rf_we, rf_waddr, rf_wdata,
           done, flag_zero, flag_carry
  );
endinterface

// File: rtl/regbank_alu_sequencer_alu.sv
// Combinational ALU for the sequencer.
//   op     : opcode
//   a, b   : operands
//   result : op(a, b) modulo 2^WIDTH
//   zero   : result == 0
//   carry  : carry out (ADD/INC), borrow (SUB), 0 otherwise
module seq_alu
  import regbank_seq_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  op_e              op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry
);

  // Extended by one bit so the top bit is carry for sums and borrow for A-B.
  logic [WIDTH:0] ext;

  always_comb begin
    ext    = '0;
    result = '0;
    carry  = 1'b0;
    unique case (op)
      OP_ADD: begin
        ext    = {1'b0, a} + {1'b0, b};
        result = ext[WIDTH-1:0];
        carry  = ext[WIDTH];
      end
      OP_SUB: begin
        ext    = {1'b0, a} - {1'b0, b};
        result = ext[WIDTH-1:0];
        carry  = ext[WIDTH];
      end
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_PASS: result = a;
      OP_INC: begin
        ext    = {1'b0, a} + (WIDTH+1)'(1);
        result = ext[WIDTH-1:0];
        carry  = ext[WIDTH];
      end
      OP_NOP:  result = '0;
      default: result = '0;
    endcase
    zero = (result == '0);
  end

endmodule

// File: rtl/regbank_alu_sequencer.sv
// Command sequencer for a 2R/1W register bank: accepts one ALU command per
// handshake, reads rs1/rs2, computes, writes the result to rd.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : command handshake, bank read/write ports, done and flags
// Accept at edge E -> rf_we/done high for the cycle after edge E+3.
module regbank_alu_sequencer
  import regbank_seq_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DEPTH = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  regbank_alu_sequencer_if.slave   bus
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             carry;
  } alu_res_t;

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [AW-1:0]    raddr_a_q, raddr_a_d;
  logic [AW-1:0]    raddr_b_q, raddr_b_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             carry_q, carry_d;
  logic             we_q, we_d;
  logic [AW-1:0]    waddr_q, waddr_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic             done_q, done_d;
  logic             ready_q, ready_d;

  logic [WIDTH-1:0] alu_result;
  logic             alu_zero;
  logic             alu_carry;
  alu_res_t         alu_res;

  seq_alu #(.WIDTH(WIDTH)) u_alu (
    .op     (op_q),
    .a      (opa_q),
    .b      (opb_q),
    .result (alu_result),
    .zero   (alu_zero),
    .carry  (alu_carry)
  );

  assign alu_res = {alu_result, alu_zero, alu_carry};

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    rd_d      = rd_q;
    raddr_a_d = raddr_a_q;
    raddr_b_d = raddr_b_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    result_d  = result_q;
    zero_d    = zero_q;
    carry_d   = carry_q;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    we_d      = 1'b0;
    done_d    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid && ready_q) begin
          op_d      = op_e'(bus.cmd_op);
          rd_d      = bus.cmd_rd;
          raddr_a_d = bus.cmd_rs1;
          raddr_b_d = bus.cmd_rs2;
          state_d   = S_READ;
        end
      end
      S_READ: begin
        opa_d   = bus.rf_rdata_a;
        opb_d   = bus.rf_rdata_b;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        result_d = alu_res.result;
        if (op_q != OP_NOP) begin
          zero_d  = alu_res.zero;
          carry_d = alu_res.carry;
        end
        state_d = S_WRITE;
      end
      S_WRITE: begin
        we_d    = (op_q != OP_NOP);
        waddr_d = rd_q;
        wdata_d = result_q;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Registered ready tracks the state being entered, so it is low in reset.
    ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      op_q      <= OP_ADD;
      rd_q      <= '0;
      raddr_a_q <= '0;
      raddr_b_q <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      result_q  <= '0;
      zero_q    <= 1'b0;
      carry_q   <= 1'b0;
      we_q      <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      done_q    <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      rd_q      <= rd_d;
      raddr_a_q <= raddr_a_d;
      raddr_b_q <= raddr_b_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      carry_q   <= carry_d;
      we_q      <= we_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      done_q    <= done_d;
      ready_q   <= ready_d;
    end
  end

  assign bus.cmd_ready  = ready_q;
  assign bus.rf_raddr_a = raddr_a_q;
  assign bus.rf_raddr_b = raddr_b_q;
  assign bus.rf_we      = we_q;
  assign bus.rf_waddr   = waddr_q;
  assign bus.rf_wdata   = wdata_q;
  assign bus.done       = done_q;
  assign bus.flag_zero  = zero_q;
  assign bus.flag_carry = carry_q;

endmodule
